// File: rtl/mult_sched.sv
// ============================================================================
// Module   : mult_sched
// Brief    : Two-requester round-robin scheduler for a shared LAT-cycle multiplier.
//            Optional counters enabled by defining MULT_SCHED_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_sched #(
    parameter int LAT = 1   // multiplier latency, legal 1..8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    input  logic        i_req0_a_ns,
    input  logic        i_req0_b_ns,
    input  logic        i_req1_a_ns,
    input  logic        i_req1_b_ns,
    input  logic        i_hold,
    output logic [31:0] o_mult_a,
    output logic [31:0] o_mult_b,
    output logic        o_multa_ns,
    output logic        o_multb_ns,
    input  logic [63:0] i_product,
    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    output logic [63:0] o_rsp_data,
    output logic        o_idle
`ifdef MULT_SCHED_PERF_EN
    ,
    output logic [31:0] o_grant0_cnt,
    output logic [31:0] o_grant1_cnt,
    output logic [31:0] o_conflict_cnt
`endif
);

    logic           prio_q, prio_d;
    logic           w_accept0, w_accept1, w_accept;
    logic [31:0]    mult_a_q, mult_a_d;
    logic [31:0]    mult_b_q, mult_b_d;
    logic           mult_a_ns_q, mult_a_ns_d;
    logic           mult_b_ns_q, mult_b_ns_d;
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q, tag_id_d;
    logic           rsp0_q, rsp0_d;
    logic           rsp1_q, rsp1_d;

    // Ready depends only on the other requester's valid, never on its own.
    always_comb begin
        o_req0_ready = ~i_hold & ~(i_req1_valid &  prio_q);
        o_req1_ready = ~i_hold & ~(i_req0_valid & ~prio_q);
        w_accept0    = i_req0_valid & o_req0_ready;
        w_accept1    = i_req1_valid & o_req1_ready;
        w_accept     = w_accept0 | w_accept1;
    end

    always_comb begin
        prio_d      = prio_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        mult_a_ns_d = mult_a_ns_q;
        mult_b_ns_d = mult_b_ns_q;
        if (w_accept0) begin
            prio_d      = 1'b1;
            mult_a_d    = i_req0_a;
            mult_b_d    = i_req0_b;
            mult_a_ns_d = i_req0_a_ns;
            mult_b_ns_d = i_req0_b_ns;
        end else if (w_accept1) begin
            prio_d      = 1'b0;
            mult_a_d    = i_req1_a;
            mult_b_d    = i_req1_b;
            mult_a_ns_d = i_req1_a_ns;
            mult_b_ns_d = i_req1_b_ns;
        end
    end

    // Tag stage 0 lines up with the issue stage; the response register
    // after stage LAT-1 coincides with the cycle i_product becomes valid.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = w_accept;
        tag_id_d[0]  = w_accept1;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        rsp0_d = tag_vld_q[LAT-1] & ~tag_id_q[LAT-1];
        rsp1_d = tag_vld_q[LAT-1] &  tag_id_q[LAT-1];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prio_q      <= 1'b0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            mult_a_ns_q <= 1'b0;
            mult_b_ns_q <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp0_q      <= 1'b0;
            rsp1_q      <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            mult_a_ns_q <= mult_a_ns_d;
            mult_b_ns_q <= mult_b_ns_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp0_q      <= rsp0_d;
            rsp1_q      <= rsp1_d;
        end
    end

    assign o_mult_a     = mult_a_q;
    assign o_mult_b     = mult_b_q;
    assign o_multa_ns   = mult_a_ns_q;
    assign o_multb_ns   = mult_b_ns_q;
    assign o_rsp0_valid = rsp0_q;
    assign o_rsp1_valid = rsp1_q;
    assign o_rsp_data   = i_product;
    assign o_idle       = ~|tag_vld_q;

`ifdef MULT_SCHED_PERF_EN
    logic [31:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (w_accept0) grant0_cnt_q <= grant0_cnt_q + 32'd1;
            if (w_accept1) grant1_cnt_q <= grant1_cnt_q + 32'd1;
            if (i_req0_valid & i_req1_valid & ~i_hold)
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign o_grant0_cnt   = grant0_cnt_q;
    assign o_grant1_cnt   = grant1_cnt_q;
    assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: one LAT=1 and one LAT=3 instance share stimulus,
// each fed by a behavioural multiplier of matching latency.
`default_nettype none

module tb_mult_sched;

    logic        clk;
    logic        rstn;
    logic        v0, v1, hold;
    logic [31:0] a0, b0, a1, b1;
    logic        a0_ns, b0_ns, a1_ns, b1_ns;

    logic        r0_1, r1_1, ans_1, bns_1, rsp0_1, rsp1_1, idle_1;
    logic [31:0] ma_1, mb_1;
    logic [63:0] prod_1, data_1;
    logic        r0_3, r1_3, ans_3, bns_3, rsp0_3, rsp1_3, idle_3;
    logic [31:0] ma_3, mb_3;
    logic [63:0] prod_3, data_3;
    logic [63:0] pipe3 [3];
`ifdef MULT_SCHED_PERF_EN
    logic [31:0] g0_1, g1_1, cf_1, g0_3, g1_3, cf_3;
`endif

    int checks = 0;
    int errors = 0;

    mult_sched #(.LAT(1)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(v0), .i_req1_valid(v1),
        .o_req0_ready(r0_1), .o_req1_ready(r1_1),
        .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
        .i_req0_a_ns(a0_ns), .i_req0_b_ns(b0_ns),
        .i_req1_a_ns(a1_ns), .i_req1_b_ns(b1_ns),
        .i_hold(hold),
        .o_mult_a(ma_1), .o_mult_b(mb_1), .o_multa_ns(ans_1), .o_multb_ns(bns_1),
        .i_product(prod_1),
        .o_rsp0_valid(rsp0_1), .o_rsp1_valid(rsp1_1), .o_rsp_data(data_1),
        .o_idle(idle_1)
`ifdef MULT_SCHED_PERF_EN
        , .o_grant0_cnt(g0_1), .o_grant1_cnt(g1_1), .o_conflict_cnt(cf_1)
`endif
    );

    mult_sched #(.LAT(3)) u_dut3 (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(v0), .i_req1_valid(v1),
        .o_req0_ready(r0_3), .o_req1_ready(r1_3),
        .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
        .i_req0_a_ns(a0_ns), .i_req0_b_ns(b0_ns),
        .i_req1_a_ns(a1_ns), .i_req1_b_ns(b1_ns),
        .i_hold(hold),
        .o_mult_a(ma_3), .o_mult_b(mb_3), .o_multa_ns(ans_3), .o_multb_ns(bns_3),
        .i_product(prod_3),
        .o_rsp0_valid(rsp0_3), .o_rsp1_valid(rsp1_3), .o_rsp_data(data_3),
        .o_idle(idle_3)
`ifdef MULT_SCHED_PERF_EN
        , .o_grant0_cnt(g0_3), .o_grant1_cnt(g1_3), .o_conflict_cnt(cf_3)
`endif
    );

    function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic ans, input logic bns);
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [65:0] p;
        sa = {ans & a[31], a};
        sb = {bns & b[31], b};
        p  = sa * sb;
        return p[63:0];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        prod_1   <= mul(ma_1, mb_1, ans_1, bns_1);
        pipe3[0] <= mul(ma_3, mb_3, ans_3, bns_3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign prod_3 = pipe3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Holds reset over two edges, checks the reset state, and returns in the
    // first cycle window after release.
    task automatic do_reset();
        rstn = 1'b0;
        v0 = 1'b0; v1 = 1'b0; hold = 1'b0;
        #1;
        chk("rst_idle1", 64'(idle_1), 64'd1);
        chk("rst_idle3", 64'(idle_3), 64'd1);
        chk("rst_rsp1",  64'({rsp0_1, rsp1_1, rsp0_3, rsp1_3}), 64'd0);
        chk("rst_mult",  {ma_1, mb_1}, 64'd0);
        chk("rst_ns",    64'({ans_1, bns_1, ans_3, bns_3}), 64'd0);
`ifdef MULT_SCHED_PERF_EN
        chk("rst_cnt",   64'(g0_1 | g1_1 | cf_1), 64'd0);
`endif
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1;
        v0 = 0; v1 = 0; hold = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        a0_ns = 0; b0_ns = 0; a1_ns = 0; b1_ns = 0;
        #3;

        // Single requester, 3*5 unsigned
        do_reset();
        v0 = 1; a0 = 32'd3; b0 = 32'd5;
        #1;
        chk("t1_rdy0", 64'(r0_1), 64'd1);
        tick(); v0 = 0;
        chk("t1_mult", {ma_1, mb_1}, {32'd3, 32'd5});
        tick();
        chk("t1_rsp0",  64'(rsp0_1), 64'd1);
        chk("t1_data",  data_1, 64'd15);
        chk("t1_rsp1",  64'(rsp1_1), 64'd0);
        tick();
        chk("t1_pulse", 64'({rsp0_1, rsp1_1}), 64'd0);
        tick();
        chk("t1_rsp0_l3", 64'(rsp0_3), 64'd1);
        chk("t1_data_l3", data_3, 64'd15);
        tick();
        chk("t1_idle", 64'({idle_1, idle_3}), 64'b11);

        // Round-robin, back-to-back
        do_reset();
        v0 = 1; a0 = 32'd3; b0 = 32'd5;
        v1 = 1; a1 = 32'd6; b1 = 32'd7;
        #1;
        chk("t2_rdy_c0", 64'({r0_1, r1_1}), 64'b10);
        tick(); a0 = 32'd4;
        #1;
        chk("t2_rdy_c1", 64'({r0_1, r1_1}), 64'b01);
        tick(); a1 = 32'd8;
        #1;
        chk("t2_rdy_c2", 64'({r0_1, r1_1}), 64'b10);
        chk("t2_rsp_c2", 64'({rsp0_1, rsp1_1}), 64'b10);
        chk("t2_dat_c2", data_1, 64'd15);
        tick();
        #1;
        chk("t2_rdy_c3", 64'({r0_1, r1_1}), 64'b01);
        chk("t2_rsp_c3", 64'({rsp0_1, rsp1_1}), 64'b01);
        chk("t2_dat_c3", data_1, 64'd42);
        tick(); v0 = 0; v1 = 0;
        chk("t2_rsp_c4", 64'({rsp0_1, rsp1_1}), 64'b10);
        chk("t2_dat_c4", data_1, 64'd20);
        tick();
        chk("t2_rsp_c5", 64'({rsp0_1, rsp1_1}), 64'b01);
        chk("t2_dat_c5", data_1, 64'd56);
        tick();
        chk("t2_rsp_c6", 64'({rsp0_1, rsp1_1}), 64'b00);

        // Signed -1 times unsigned 2 on requester 1
        do_reset();
        v1 = 1; a1 = 32'hFFFF_FFFF; a1_ns = 1; b1 = 32'd2; b1_ns = 0;
        #1;
        chk("t3_rdy1", 64'(r1_1), 64'd1);
        tick(); v1 = 0;
        chk("t3_ns", 64'({ans_1, bns_1}), 64'b10);
        tick();
        chk("t3_rsp", 64'({rsp0_1, rsp1_1}), 64'b01);
        chk("t3_data", data_1, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        tick();
        chk("t3_rsp_l3", 64'({rsp0_3, rsp1_3}), 64'b01);
        chk("t3_data_l3", data_3, 64'hFFFF_FFFF_FFFF_FFFE);
        a1_ns = 0;

        // Hold with three operations in flight, LAT=3
        do_reset();
        v0 = 1; a0 = 32'd3; b0 = 32'd5;
        v1 = 1; a1 = 32'd6; b1 = 32'd7;
        tick(); a0 = 32'd4;
        tick();
        tick(); hold = 1;
        #1;
        chk("t4_rdy_c3", 64'({r0_3, r1_3}), 64'b00);
        chk("t4_busy",   64'(idle_3), 64'd0);
        tick();
        #1;
        chk("t4_rdy_c4", 64'({r0_3, r1_3}), 64'b00);
        chk("t4_rsp_c4", 64'({rsp0_3, rsp1_3}), 64'b10);
        chk("t4_dat_c4", data_3, 64'd15);
        tick();
        chk("t4_rsp_c5", 64'({rsp0_3, rsp1_3}), 64'b01);
        chk("t4_dat_c5", data_3, 64'd42);
        tick();
        chk("t4_rsp_c6", 64'({rsp0_3, rsp1_3}), 64'b10);
        chk("t4_dat_c6", data_3, 64'd20);
        chk("t4_idle",   64'(idle_3), 64'd1);
        tick(); v0 = 0; v1 = 0; hold = 0;
        chk("t4_rsp_c7", 64'({rsp0_3, rsp1_3}), 64'b00);

        // Reset with operations in flight
        do_reset();
        v0 = 1; a0 = 32'd3; b0 = 32'd5;
        v1 = 1; a1 = 32'd6; b1 = 32'd7;
        tick();
        tick(); v0 = 0; v1 = 0;
        chk("t5_inflight", 64'(idle_3), 64'd0);
        do_reset();
        v0 = 1; v1 = 1;
        #1;
        chk("t5_prio1", 64'({r0_1, r1_1}), 64'b10);
        chk("t5_prio3", 64'({r0_3, r1_3}), 64'b10);
        v0 = 0; v1 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_norsp", 64'({rsp0_1, rsp1_1, rsp0_3, rsp1_3}), 64'd0);
            chk("t5_idle",  64'({idle_1, idle_3}), 64'b11);
        end

`ifdef MULT_SCHED_PERF_EN
        do_reset();
        v0 = 1; v1 = 1;
        repeat (10) tick();
        v0 = 0; v1 = 0;
        chk("t6_g0", 64'(g0_1), 64'd5);
        chk("t6_g1", 64'(g1_1), 64'd5);
        chk("t6_cf", 64'(cf_1), 64'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter LAT, default 1: cycles from operands presented on o_mult_* to a valid i_product; legal range 1..8.
REQ-002 SHALL have i_clk input 1 as the single clock; all state changes on its rising edge.
REQ-003 SHALL have i_rstn input 1 as the reset: asynchronous assert, active-low.
REQ-004 SHALL have i_req0_valid, i_req1_valid inputs 1: requester n has an operation pending.
REQ-005 SHALL have o_req0_ready, o_req1_ready outputs 1: requester n accepted this cycle when valid & ready.
REQ-006 SHALL have i_reqN_a, i_reqN_b inputs 32 each (N=0,1): multiplicand and multiplier.
REQ-007 SHALL have i_reqN_a_ns, i_reqN_b_ns inputs 1 each: operand signedness, 1 = signed.
REQ-008 SHALL have i_hold input 1: stop accepting new operations.
REQ-009 SHALL have o_mult_a, o_mult_b outputs 32 and o_multa_ns, o_multb_ns outputs 1: registered operands to the shared multiplier.
REQ-010 SHALL have i_product input 64: multiplier result.
REQ-011 SHALL have o_rsp0_valid, o_rsp1_valid outputs 1 and o_rsp_data output 64: one-cycle result pulse to the owning requester, shared data bus.
REQ-012 SHALL have o_idle output 1: high when nothing is in flight.

Function
REQ-013 SHALL accept at most one operation per cycle; a requester's ready SHALL NOT depend on its own valid.
REQ-014 SHALL arbitrate round-robin with a 1-bit priority pointer prio: o_req0_ready = !i_hold & !(i_req1_valid & prio==1); o_req1_ready = !i_hold & !(i_req0_valid & prio==0).
REQ-015 SHALL set prio to the other requester after every accepted grant; with no grant, prio SHALL hold.
REQ-016 SHALL, with a single valid requester and i_hold low, grant it regardless of prio.
REQ-017 SHALL register the granted requester's operands and ns bits into o_mult_* one cycle after acceptance; o_mult_* SHALL hold their last values when nothing is accepted.
REQ-018 SHALL carry a valid+id tag through a LAT-deep shift register starting at the issue stage.
REQ-019 SHALL drive o_rspN_valid high for exactly one cycle, 1+LAT cycles after acceptance, for the tag id N, with o_rsp_data = i_product in that cycle (combinational pass-through).
REQ-020 SHALL sustain back-to-back issue (one result per cycle) with results returned strictly in acceptance order.
REQ-021 SHALL drive o_rsp_data to i_product unconditionally; only the valid pulses qualify it.
REQ-022 SHALL compute o_idle as no tag valid in any stage, issue stage included.
REQ-023 SHALL let in-flight operations drain and deliver results normally while i_hold is high.
REQ-024 SHALL require the requester to hold operands stable while valid & !ready (standard valid/ready protocol).

Reset
REQ-025 SHALL, on i_rstn low, asynchronously clear all tags, o_rspN_valid, o_mult_*, o_multa_ns and o_multb_ns to 0, set prio to 0 and o_idle to 1.
REQ-026 SHALL discard results in flight at reset assertion and never deliver them after release.

Configuration
REQ-027 SHALL compile in, only when MULT_SCHED_PERF_EN is defined, outputs o_grant0_cnt, o_grant1_cnt and o_conflict_cnt (32 bits each), reset to 0.
REQ-028 SHALL, with MULT_SCHED_PERF_EN defined, increment o_grantN_cnt per acceptance from requester N and o_conflict_cnt per cycle with both valid and i_hold low; all three SHALL wrap 0xFFFFFFFF->0.
REQ-029 SHALL, without MULT_SCHED_PERF_EN, omit these ports and counters entirely, with all other behaviour identical.

Verification
REQ-030 SHALL verify: LAT=1, req0 only with a=3, b=5, unsigned -> o_rsp0_valid 2 cycles later, o_rsp_data=15, o_rsp1_valid stays 0.
REQ-031 SHALL verify: both valid for 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp0, rsp1, rsp0, rsp1 back-to-back.
REQ-032 SHALL verify: req1 a=0xFFFFFFFF signed, b=2 unsigned -> o_rsp1_valid with o_rsp_data=0xFFFFFFFFFFFFFFFE.
REQ-033 SHALL verify: i_hold high with 3 ops in flight, LAT=3 -> both readies 0, all 3 results delivered, then o_idle=1.
REQ-034 SHALL verify: i_rstn pulsed low with 2 ops in flight -> no rsp pulses afterwards, prio=0, o_idle=1.
REQ-035 SHALL verify: with MULT_SCHED_PERF_EN, 10 cycles of both valid -> o_grant0_cnt=5, o_grant1_cnt=5, o_conflict_cnt=10.
